// File: rtl/seq_adder.sv
// Digit-serial add/subtract unit: processes DIGIT bits per clock and delivers
// sum/difference plus carry/borrow and signed-overflow flags after WIDTH/DIGIT RUN cycles.
module seq_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] adder_out,
    output logic             c,
    output logic             v
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]    CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(N - 1);
    localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             accept_s;
    logic             last_s;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] adder_out_r;
    logic             carry_r;
    logic             sub_r;
    logic             c_r;
    logic             v_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [DIGIT:0]   slice_sum_s;
    logic             msb_carry_in_s;
    logic [31:0]      digit_lo_s;
    logic [WIDTH-1:0] slice_mask_s;
    logic [WIDTH-1:0] slice_ins_s;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; DONE accepts a new start exactly like IDLE
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    last_s       = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= (state_next_s != ST_RUN);
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operands shift right each RUN edge, so the active digit is always the low DIGIT bits.
    // Carry into the MSB is recovered from the MSB sum bit: cin = a ^ b ^ s.
    always_comb begin
        slice_sum_s    = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_r};
        msb_carry_in_s = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_sum_s[DIGIT-1];
        digit_lo_s     = 32'(cnt_r) * 32'(DIGIT);
        slice_mask_s   = DIGIT_MASK << digit_lo_s;
        slice_ins_s    = WIDTH'(slice_sum_s[DIGIT-1:0]) << digit_lo_s;
    end

    // Operand capture, per-digit accumulate, and flag update on the final digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            sub_r       <= 1'b0;
            cnt_r       <= CNT_ZERO;
            adder_out_r <= {WIDTH{1'b0}};
            c_r         <= 1'b0;
            v_r         <= 1'b0;
        end else if (accept_s) begin
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            sub_r   <= sub;
            cnt_r   <= CNT_ZERO;
        end else if (state_r == ST_RUN) begin
            a_r         <= a_r >> DIGIT;
            b_r         <= b_r >> DIGIT;
            adder_out_r <= (adder_out_r & ~slice_mask_s) | slice_ins_s;
            carry_r     <= slice_sum_s[DIGIT];
            if (last_s) begin
                cnt_r <= CNT_ZERO;
                c_r   <= slice_sum_s[DIGIT] ^ sub_r;
                v_r   <= msb_carry_in_s ^ slice_sum_s[DIGIT];
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign adder_out = adder_out_r;
    assign c         = c_r;
    assign v         = v_r;

endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed corner cases on DIGIT=8 plus
// randomized operations on DIGIT=8,1,4,32 instances against an arithmetic reference.
module tb_seq_adder;

    logic        clk;
    logic        rst;
    logic        start_w [4];
    logic        sub_w   [4];
    logic [31:0] a_w     [4];
    logic [31:0] b_w     [4];
    logic        ready_w [4];
    logic        busy_w  [4];
    logic        done_w  [4];
    logic [31:0] out_w   [4];
    logic        c_w     [4];
    logic        v_w     [4];

    int checks = 0;
    int errors = 0;
    int n_tab [4] = '{4, 32, 8, 1};

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DG = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        seq_adder #(.WIDTH(32), .DIGIT(DG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_w[g]),
            .sub       (sub_w[g]),
            .a         (a_w[g]),
            .b         (b_w[g]),
            .ready     (ready_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .adder_out (out_w[g]),
            .c         (c_w[g]),
            .v         (v_w[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the operands
    task automatic model(input logic s, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic cc, output logic vv);
        longint sx;
        longint sy;
        longint sr;
        logic [32:0] wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!s) begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[31:0];
            cc   = wide[32];
            sr   = sx + sy;
        end else begin
            r  = x - y;
            cc = (x < y);
            sr = sx - sy;
        end
        vv = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    endtask

    // Starts an op now; returns at the sample point of the done cycle
    task automatic op(input int idx, input logic s, input logic [31:0] x,
                      input logic [31:0] y, input bit poke);
        logic [31:0] er;
        logic        ec;
        logic        ev;
        int          cyc;
        bit          seen;
        model(s, x, y, er, ec, ev);
        sub_w[idx]   = s;
        a_w[idx]     = x;
        b_w[idx]     = y;
        start_w[idx] = 1'b1;
        @(posedge clk); #1;
        start_w[idx] = 1'b0;
        check($sformatf("busy_after_accept[%0d]", idx), 32'(busy_w[idx]), 32'd1);
        check($sformatf("ready_after_accept[%0d]", idx), 32'(ready_w[idx]), 32'd0);
        if (poke) begin
            start_w[idx] = 1'b1;
            sub_w[idx]   = ~s;
            a_w[idx]     = 32'hDEADBEEF;
            b_w[idx]     = 32'h01234567;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < n_tab[idx] + 4) begin
            @(posedge clk); #1;
            cyc++;
            start_w[idx] = 1'b0;
            seen = done_w[idx];
        end
        check($sformatf("latency[%0d]", idx), 32'(cyc), 32'(n_tab[idx]));
        check($sformatf("sum[%0d] %0h%s%0h", idx, x, s ? "-" : "+", y), out_w[idx], er);
        check($sformatf("c[%0d] %0h%s%0h", idx, x, s ? "-" : "+", y), 32'(c_w[idx]), 32'(ec));
        check($sformatf("v[%0d] %0h%s%0h", idx, x, s ? "-" : "+", y), 32'(v_w[idx]), 32'(ev));
        check($sformatf("ready_in_done[%0d]", idx), 32'(ready_w[idx]), 32'd1);
    endtask

    initial begin
        bit          seen_s;
        logic        rs;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int i = 0; i < 4; i++) begin
            start_w[i] = 1'b0;
            sub_w[i]   = 1'b0;
            a_w[i]     = 32'd0;
            b_w[i]     = 32'd0;
        end
        rst = 1'b0;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(ready_w[0]), 32'd1);
        check("reset_busy", 32'(busy_w[0]), 32'd0);
        check("reset_done", 32'(done_w[0]), 32'd0);
        check("reset_c", 32'(c_w[0]), 32'd0);
        check("reset_v", 32'(v_w[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_out[%0d]", i), out_w[i], 32'd0);
        end
        @(posedge clk); #1;

        // Basic add, then done must drop after one cycle with results held
        op(0, 1'b0, 32'd5, 32'd3, 1'b0);
        check("add_5_3_const", out_w[0], 32'd8);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done_w[0]), 32'd0);
        check("hold_out_idle", out_w[0], 32'd8);
        check("ready_idle", 32'(ready_w[0]), 32'd1);

        // Borrow cases, issued back-to-back from the DONE cycle
        op(0, 1'b1, 32'd0, 32'd1, 1'b0);
        check("sub_0_1_const", out_w[0], 32'hFFFFFFFF);
        op(0, 1'b1, 32'd5, 32'd5, 1'b0);
        check("sub_5_5_const", out_w[0], 32'd0);

        // Overflow and carry boundaries
        op(0, 1'b0, 32'h7FFFFFFF, 32'd1, 1'b0);
        check("ovf_add_v_const", 32'(v_w[0]), 32'd1);
        op(0, 1'b1, 32'h80000000, 32'd1, 1'b0);
        check("ovf_sub_out_const", out_w[0], 32'h7FFFFFFF);
        op(0, 1'b0, 32'hFFFFFFFF, 32'd1, 1'b0);
        check("carry_add_c_const", 32'(c_w[0]), 32'd1);
        @(posedge clk); #1;

        // Start while busy is ignored
        op(0, 1'b0, 32'd5, 32'd3, 1'b1);
        check("busy_start_ignored", out_w[0], 32'd8);

        // Async reset in the middle of RUN
        op(0, 1'b1, 32'd0, 32'd1, 1'b0);
        sub_w[0]   = 1'b0;
        a_w[0]     = 32'd1;
        b_w[0]     = 32'd2;
        start_w[0] = 1'b1;
        @(posedge clk); #1;
        start_w[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrun_rst_out", out_w[0], 32'd0);
        check("midrun_rst_c", 32'(c_w[0]), 32'd0);
        check("midrun_rst_v", 32'(v_w[0]), 32'd0);
        check("midrun_rst_busy", 32'(busy_w[0]), 32'd0);
        check("midrun_rst_ready", 32'(ready_w[0]), 32'd1);
        check("midrun_rst_done", 32'(done_w[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_s = 1'b0;
        repeat (n_tab[0] + 3) begin
            @(posedge clk); #1;
            if (done_w[0]) seen_s = 1'b1;
        end
        check("no_done_after_rst", 32'(seen_s), 32'd0);
        op(0, 1'b0, 32'h12345678, 32'h11111111, 1'b0);

        // Randomized sweep over all digit sizes
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k < 20; k++) begin
                rs = 1'($urandom_range(0, 1));
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
                if ($urandom_range(0, 4) == 0) ra = ra ^ 32'h80000000;
                op(d, rs, ra, rb, 1'b0);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk); #1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
